// File: rtl/ssm_pkg.sv
// Shared SSM constants: FP16 width, multiplier/adder latency defaults, requester ids.
// Latency: n/a (package). Backpressure: n/a.
package ssm_pkg;

  localparam int FP16_W    = 16;
  localparam int M_LAT_DEF = 6;
  localparam int A_LAT_DEF = 4;
  localparam int NREQ_DEF  = 5;

  typedef enum logic [2:0] {
    REQ_DX  = 3'd0,
    REQ_DXB = 3'd1,
    REQ_DAH = 3'd2,
    REQ_HC  = 3'd3,
    REQ_XD  = 3'd4
  } req_id_e;

  // Requester-id width; a single bit is kept even for two requesters.
  function automatic int tw_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of mask scanning upward from ptr with wrap.
// Latency: combinational. Backpressure: none.
module rr_pick #(
  parameter int N  = 5,
  parameter int TW = 3
) (
  input  logic [N-1:0]  mask,
  input  logic [TW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [TW-1:0] idx,
  output logic          any
);

  int          ci;
  logic [TW-1:0] c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    ci  = 0;
    c   = '0;
    for (int i = 0; i < N; i++) begin
      ci = int'(ptr) + i;
      if (ci >= N) ci = ci - N;
      c = TW'(ci);
      if (!any && mask[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Shares one fixed-latency FP16 multiplier among NREQ requesters (round-robin, burst lock, hold).
// Latency: handshake to res_valid is M_LAT+2 cycles. Backpressure: hold gates grants; results cannot stall.
module fp16_mul_arbiter
  import ssm_pkg::*;
#(
  parameter int  NREQ  = NREQ_DEF,
  parameter int  DW    = FP16_W,
  parameter int  M_LAT = M_LAT_DEF,
  localparam int TW    = tw_of(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*DW-1:0] req_a_flat,
  input  logic [NREQ*DW-1:0] req_b_flat,
  output logic [NREQ-1:0]    req_ready,
  input  logic               hold,
  output logic [DW-1:0]      mul_a,
  output logic [DW-1:0]      mul_b,
  output logic               mul_in_valid,
  input  logic [DW-1:0]      mul_y,
  output logic [NREQ-1:0]    res_valid,
  output logic [DW-1:0]      res_data,
  output logic [TW-1:0]      grant_id,
  output logic               idle
);

  localparam int CW = $clog2(M_LAT + 3);

  typedef struct packed {
    logic          vld;
    logic [TW-1:0] id;
  } tag_t;

  logic [TW-1:0]   ptr_q, ptr_d;
  logic            lock_q, lock_d;
  logic [TW-1:0]   locked_id_q, locked_id_d;
  logic [DW-1:0]   mul_a_q, mul_a_d;
  logic [DW-1:0]   mul_b_q, mul_b_d;
  logic            mul_in_valid_q, mul_in_valid_d;
  logic [TW-1:0]   grant_id_q, grant_id_d;
  tag_t            tag_q [M_LAT];
  tag_t            tag_d [M_LAT];
  logic [NREQ-1:0] res_valid_q, res_valid_d;
  logic [DW-1:0]   res_data_q, res_data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            idle_q, idle_d;

  logic [NREQ-1:0] elig, lock_mask, gnt;
  logic [TW-1:0]   gidx;
  logic            hs;

  // A held lock narrows eligibility to the owner, so its absence leaves a bubble.
  always_comb begin
    lock_mask              = '0;
    lock_mask[locked_id_q] = 1'b1;
    elig                   = req_valid & ~{NREQ{hold}};
    if (lock_q) elig = elig & lock_mask;
  end

  rr_pick #(
    .N  (NREQ),
    .TW (TW)
  ) u_pick (
    .mask (elig),
    .ptr  (ptr_q),
    .gnt  (gnt),
    .idx  (gidx),
    .any  (hs)
  );

  assign req_ready = gnt;

  always_comb begin
    ptr_d          = ptr_q;
    lock_d         = lock_q;
    locked_id_d    = locked_id_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    mul_in_valid_d = hs;
    grant_id_d     = grant_id_q;
    if (hs) begin
      grant_id_d = gidx;
      if (req_lock[gidx]) begin
        lock_d      = 1'b1;
        locked_id_d = gidx;
      end else begin
        lock_d = 1'b0;
        ptr_d  = (gidx == TW'(NREQ - 1)) ? '0 : gidx + TW'(1);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          mul_a_d = req_a_flat[i*DW +: DW];
          mul_b_d = req_b_flat[i*DW +: DW];
        end
      end
    end
  end

  // Tags enter one cycle after issue so the last stage lines up with mul_y.
  always_comb begin
    tag_d[0] = '{vld: mul_in_valid_q, id: grant_id_q};
    for (int k = 1; k < M_LAT; k++) tag_d[k] = tag_q[k-1];
  end

  always_comb begin
    res_valid_d = '0;
    res_data_d  = res_data_q;
    if (tag_q[M_LAT-1].vld) begin
      res_valid_d[tag_q[M_LAT-1].id] = 1'b1;
      res_data_d                     = mul_y;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({mul_in_valid_q, |res_valid_q})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    idle_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q          <= '0;
      lock_q         <= 1'b0;
      locked_id_q    <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_in_valid_q <= 1'b0;
      grant_id_q     <= '0;
      for (int k = 0; k < M_LAT; k++) tag_q[k] <= '0;
      res_valid_q    <= '0;
      res_data_q     <= '0;
      cnt_q          <= '0;
      idle_q         <= 1'b1;
    end else begin
      ptr_q          <= ptr_d;
      lock_q         <= lock_d;
      locked_id_q    <= locked_id_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      mul_in_valid_q <= mul_in_valid_d;
      grant_id_q     <= grant_id_d;
      for (int k = 0; k < M_LAT; k++) tag_q[k] <= tag_d[k];
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      cnt_q          <= cnt_d;
      idle_q         <= idle_d;
    end
  end

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign mul_in_valid = mul_in_valid_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign grant_id     = grant_id_q;
  assign idle         = idle_q;

endmodule

// File: doc/fp16_mul_arbiter.md
Name: fp16_mul_arbiter

Overview:
- Shares one fixed-latency FP16 multiplier (M_LAT pipeline stages, no stall) among NREQ requesters in the SSM block, e.g. dx, dxB, dAh, hC and xD.
- Round-robin arbiter with optional burst lock and a drain hold.
- Results route back to the issuing requester through an internal tag pipeline.
- The top-level stage FSM uses `hold` and `idle` to fence stage transitions.

Parameters:
- NREQ, 5, number of requesters (2..8).
- DW, 16, operand/result width (FP16).
- M_LAT, 6, multiplier latency in cycles from mul_in_valid to mul_y.
- TW, localparam = max(1, clog2(NREQ)), requester-id width.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  NREQ  per-requester operand-pair valid.
- req_lock  in  NREQ  per-requester burst lock, sampled on handshake.
- req_a_flat  in  NREQ*DW  operand A; requester i occupies bits [i*DW +: DW].
- req_b_flat  in  NREQ*DW  operand B, same packing as req_a_flat.
- req_ready  out  NREQ  one-hot grant, combinational, same cycle as valid.
- hold  in  1  blocks new grants; in-flight operations still complete.
- mul_a  out  DW  registered operand A to the multiplier.
- mul_b  out  DW  registered operand B to the multiplier.
- mul_in_valid  out  1  registered issue strobe.
- mul_y  in  DW  multiplier product, valid exactly M_LAT cycles after mul_in_valid.
- res_valid  out  NREQ  registered one-hot result strobe.
- res_data  out  DW  registered product, broadcast to all requesters.
- grant_id  out  TW  id of the last issued requester (debug).
- idle  out  1  registered; high when nothing is in flight.

Behaviour:
- Reset (rst=0, asynchronous) clears everything:
  - mul_a/mul_b/res_data = 0; mul_in_valid = 0; res_valid = 0.
  - grant_id = 0; round-robin pointer = 0; lock = cleared; in-flight count = 0; tag pipe valids = 0.
  - idle = 1.
  - Reset mid-operation discards all in-flight results; no res_valid is produced for them.
- Eligibility: eligible = req_valid & ~{NREQ{hold}}.
  - While lock is set, only locked_id is eligible.
- Grant: the first eligible requester scanning from the pointer upward with wrap-around.
  - req_ready = onehot(g), or 0 if nothing is eligible.
  - Handshake = req_valid[g] & req_ready[g], at cycle t.
- Pointer and lock update on handshake:
  - req_lock[g]=1: set lock, locked_id = g; pointer unchanged.
  - req_lock[g]=0: clear lock; pointer = (g+1) mod NREQ.
  - No handshake: pointer and lock hold.
  - A locked requester dropping req_valid stalls all others (bubble) until it reissues, or until reset.
- Issue, cycle t+1:
  - mul_a/mul_b = operands of g; mul_in_valid = 1; grant_id = g.
  - Without a handshake: mul_in_valid = 0 and operands hold their values.
- Tag pipeline: {valid, id} shift register of depth M_LAT, aligned to mul_y.
- Result, cycle t+M_LAT+1: res_data = mul_y, res_valid = onehot(id) registered.
  - End-to-end latency from handshake to res_valid is M_LAT+2 cycles.
  - No backpressure on results; requesters must accept them.
  - res_data holds when no result is valid.
- Throughput: one issue per cycle sustained, including back-to-back from a single requester.
- In-flight counter:
  - +1 on issue, −1 on res_valid; both in the same cycle leaves it unchanged.
  - Width covers a maximum of M_LAT+2.
  - idle = (counter == 0) registered; deasserts the cycle after the first issue.
- hold:
  - hold=1 in cycle t gives req_ready=0 in cycle t; the lock state is retained.
  - Deasserting hold resumes from the stored pointer/lock.

Decomposition:
- Shared package `ssm_pkg`:
  - FP16 width constant (DW=16) and M_LAT/A_LAT defaults.
  - Requester-index constants: REQ_DX=0, REQ_DXB=1, REQ_DAH=2, REQ_HC=3, REQ_XD=4.
- One sub-module is natural: `rr_pick`, a combinational round-robin priority picker taking (mask, pointer) and returning the one-hot grant and its index.

Test Plan:
- Single requester 0 issuing 1.0×2.0 (0x3C00, 0x4000) → req_ready[0] same cycle; res_valid=5'b00001 with res_data=0x4000 exactly M_LAT+2=8 cycles later; idle high→low→high.
- All 5 requesters valid continuously, each with distinct operands → grants in order 0,1,2,3,4,0,…; one mul_in_valid per cycle; each result returns to the correct res_valid bit in issue order.
- Requester 2 issues 3 ops with req_lock=1,1,0 while 0 and 4 are also valid → grants 2,2,2, then 4, then 0; pointer lands at 1 after the grant to 0.
- hold=1 during 4 cycles with 3 ops in flight → no req_ready; all 3 results still delivered; idle rises once they have drained; grants resume at the stored pointer after hold=0.
- Assert rst=0 asynchronously with 4 ops in flight and a lock set → all outputs zero immediately, idle=1; no stale res_valid after release; the first grant after release goes to requester 0.
- Issue and result retire in the same cycle on a steady 1-requester stream → in-flight count constant at M_LAT+1 (7); idle stays 0.
